sram_stream_engine: RTL and testbench

Parametrised SRAM-to-SRAM streaming engine. On a `dut_run` start it reads a length header from the input SRAM, streams that many words through a selectable transform, and writes the results to the output SRAM, pipelining one read per cycle against a configurable SRAM read latency. It sits between the top-level run/busy handshake and the input/output SRAM ports.

---
 rtl/sram_stream_engine.sv | 110 +++++++++++
 tb/tb_sram_stream_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_engine.sv
// sram_stream_engine: streams a length-prefixed block from input SRAM through a transform into output SRAM
module sram_stream_engine #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int RD_LAT   = 1,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 0,
    parameter int MAX_LEN  = 1024
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    input  logic [1:0]        dut_mode,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] sram_dut_read_addr,
    input  logic [DATA_W-1:0] dut_sram_read_data,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_sram_write_addr,
    output logic [DATA_W-1:0] dut_sram_write_data
);
    typedef enum logic [2:0] {IDLE, HDR_WAIT, STREAM, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, len, wcnt, hdr_len;
    logic [RD_LAT-1:0]   tags, tags_nxt;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   acc, y;
    logic [31:0]         hdr;
    logic                hdr_ready, last_issue;

    assign hdr        = 32'(dut_sram_read_data);
    assign hdr_len    = (hdr > 32'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : ADDR_W'(hdr);
    assign hdr_ready  = (state == HDR_WAIT) && (cnt == ADDR_W'(RD_LAT));
    assign last_issue = (state == STREAM) && (cnt == len - 1'b1);
    // a tag marks a word whose address is on the bus this cycle; it surfaces when that word's data is valid
    assign tags_nxt   = (tags << 1) | RD_LAT'(state == STREAM);

    // acc holds the running sum for prefix mode and the previous input word for delta mode
    always_comb begin
        y = (mode_q == 2'b00) ? dut_sram_read_data :
            (mode_q == 2'b01) ? acc + dut_sram_read_data :
            (mode_q == 2'b10) ? dut_sram_read_data - acc : ~dut_sram_read_data;
    end

    // state register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (dut_run) state_nxt = HDR_WAIT;
            HDR_WAIT: if (hdr_ready) state_nxt = (hdr_len == '0) ? DONE : STREAM;
            STREAM:   if (last_issue) state_nxt = DRAIN;
            DRAIN:    if (tags_nxt == '0) state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    // read issue, tag pipeline, transform and write port
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            dut_busy              <= 1'b0;
            sram_dut_read_addr    <= '0;
            dut_sram_write_enable <= 1'b0;
            dut_sram_write_addr   <= '0;
            dut_sram_write_data   <= '0;
            tags                  <= '0;
            cnt                   <= '0;
            len                   <= '0;
            wcnt                  <= '0;
            acc                   <= '0;
            mode_q                <= 2'b00;
        end else begin
            tags                  <= tags_nxt;
            dut_sram_write_enable <= tags[RD_LAT-1];
            if (tags[RD_LAT-1]) begin
                dut_sram_write_data <= y;
                dut_sram_write_addr <= ADDR_W'(DST_BASE) + wcnt;
                wcnt                <= wcnt + 1'b1;
                acc                 <= (mode_q == 2'b01) ? y : dut_sram_read_data;
            end
            if (state == IDLE && dut_run) begin
                dut_busy           <= 1'b1;
                sram_dut_read_addr <= ADDR_W'(SRC_BASE);
                mode_q             <= dut_mode;
                cnt                <= '0;
                wcnt               <= '0;
                acc                <= '0;
            end
            if (state == HDR_WAIT) begin
                if (hdr_ready) begin
                    len                <= hdr_len;
                    sram_dut_read_addr <= ADDR_W'(SRC_BASE + 1);
                    cnt                <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == STREAM && !last_issue) begin
                sram_dut_read_addr <= sram_dut_read_addr + 1'b1;
                cnt                <= cnt + 1'b1;
            end
            if (state == DONE) dut_busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sram_stream_engine.sv
// tb_sram_stream_engine: randomized self-checking bench for sram_stream_engine against a word-level model
module tb_sram_stream_engine;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [1:0]  run = 2'b00;
    logic [1:0]  mode = 2'b00;
    logic        busy [2];
    logic        wen [2];
    logic [11:0] raddr [2];
    logic [11:0] waddr [2];
    logic [15:0] wdata [2];
    logic [15:0] rd [2];
    logic [15:0] mem [2][4096];
    logic [11:0] ap0;
    logic [11:0] ap1 [3];
    int          cyc = 0, start_cyc = 0, act = 0, bcnt = 0, bfirst = -1;
    int          checks = 0, fails = 0;
    int          cap_a[$], cap_d[$], cap_c[$];
    logic [15:0] xq[$];

    // unit 0: RD_LAT=1, default bases and clamp; unit 1: RD_LAT=3, MAX_LEN=4, bases near the top of memory
    sram_stream_engine #(.RD_LAT(1)) u0 (
        .clk(clk), .reset_b(reset_b), .dut_run(run[0]), .dut_mode(mode), .dut_busy(busy[0]),
        .sram_dut_read_addr(raddr[0]), .dut_sram_read_data(rd[0]), .dut_sram_write_enable(wen[0]),
        .dut_sram_write_addr(waddr[0]), .dut_sram_write_data(wdata[0]));
    sram_stream_engine #(.RD_LAT(3), .MAX_LEN(4), .SRC_BASE(4093), .DST_BASE(4094)) u1 (
        .clk(clk), .reset_b(reset_b), .dut_run(run[1]), .dut_mode(mode), .dut_busy(busy[1]),
        .sram_dut_read_addr(raddr[1]), .dut_sram_read_data(rd[1]), .dut_sram_write_enable(wen[1]),
        .dut_sram_write_addr(waddr[1]), .dut_sram_write_data(wdata[1]));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        ap0    <= raddr[0];
        ap1[0] <= raddr[1];
        ap1[1] <= ap1[0];
        ap1[2] <= ap1[1];
    end

    assign rd[0] = mem[0][ap0];
    assign rd[1] = mem[1][ap1[2]];

    always @(negedge clk) begin
        if (reset_b) begin
            if (wen[act]) begin
                cap_a.push_back(int'(waddr[act]));
                cap_d.push_back(int'(wdata[act]));
                cap_c.push_back(cyc - start_cyc);
            end
            if (busy[act]) begin
                if (bfirst < 0) bfirst = cyc - start_cyc;
                bcnt++;
            end
        end
    end

    task automatic clear_caps();
        cap_a.delete();
        cap_d.delete();
        cap_c.delete();
        bcnt = 0;
        bfirst = -1;
    endtask

    task automatic test_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], wen[d], raddr[d], waddr[d], wdata[d]} !== 41'd0) begin
                fails++;
                $display("FAIL reset_outputs unit %0d: got %h, want 0", d, {busy[d], wen[d], raddr[d], waddr[d], wdata[d]});
            end
        end
        @(negedge clk);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_job(input int d, input logic [1:0] m, input logic [15:0] hdr, input bit hold, input string name);
        int lat = d ? 3 : 1;
        int ml  = d ? 4 : 1024;
        int sb  = d ? 4093 : 0;
        int db  = d ? 4094 : 0;
        int n   = (int'(hdr) > ml) ? ml : int'(hdr);
        int exp_busy = (n == 0) ? lat + 2 : n + 2 * lat + 2;
        logic [15:0] sum = 16'h0, prev = 16'h0, x, y;
        bit done = 1'b0;
        mem[d][sb] = hdr;
        for (int i = 0; i < xq.size(); i++) mem[d][(sb + 1 + i) % 4096] = xq[i];
        act = d;
        clear_caps();
        @(negedge clk);
        run[d] = 1'b1;
        mode = m;
        start_cyc = cyc + 1;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (!hold) run[d] = 1'b0;
            if (!busy[d]) done = 1'b1;
        end
        run[d] = 1'b0;
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL %s timeout: busy still high after 3000 cycles", name);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (cap_d.size() !== n) begin
            fails++;
            $display("FAIL %s write_count: got %0d, want %0d", name, cap_d.size(), n);
        end
        for (int i = 0; i < n && i < cap_d.size(); i++) begin
            x = xq[i];
            sum = sum + x;
            y = (m == 2'd0) ? x : (m == 2'd1) ? sum : (m == 2'd2) ? x - prev : ~x;
            prev = x;
            checks++;
            if (cap_d[i] !== int'(y)) begin
                fails++;
                $display("FAIL %s data[%0d]: got %h, want %h", name, i, cap_d[i], y);
            end
            checks++;
            if (cap_a[i] !== (db + i) % 4096) begin
                fails++;
                $display("FAIL %s addr[%0d]: got %0d, want %0d", name, i, cap_a[i], (db + i) % 4096);
            end
            checks++;
            if (cap_c[i] !== 2 * lat + 2 + i) begin
                fails++;
                $display("FAIL %s cycle[%0d]: got %0d, want %0d", name, i, cap_c[i], 2 * lat + 2 + i);
            end
        end
        checks++;
        if (bcnt !== exp_busy || bfirst !== 0) begin
            fails++;
            $display("FAIL %s busy: got %0d cycles from cycle %0d, want %0d from cycle 0", name, bcnt, bfirst, exp_busy);
        end
    endtask

    task automatic test_copy();
        xq = '{16'h0001, 16'h0002, 16'h0003};
        test_job(0, 2'd0, 16'd3, 1'b0, "copy");
    endtask

    task automatic test_prefix_wrap();
        xq = '{16'hFFFF, 16'h0003};
        test_job(0, 2'd1, 16'd2, 1'b0, "prefix_wrap");
    endtask

    task automatic test_delta_invert();
        xq = '{16'd5, 16'd9, 16'd4};
        test_job(0, 2'd2, 16'd3, 1'b0, "delta");
        xq = '{16'h00FF};
        test_job(0, 2'd3, 16'd1, 1'b0, "invert");
    endtask

    task automatic test_boundaries();
        xq = '{16'h1234};
        test_job(0, 2'd0, 16'd0, 1'b0, "zero_len");
        xq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        test_job(1, 2'd1, 16'hFFFF, 1'b0, "clamp_wrap");
        xq = '{16'hA5A5, 16'h0F0F, 16'h7777};
        test_job(0, 2'd2, 16'd3, 1'b1, "hold_run");
    endtask

    task automatic test_latency();
        xq = '{16'hBEEF, 16'hCAFE};
        test_job(1, 2'd0, 16'd2, 1'b0, "latency3");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int n = $urandom_range(1, 12);
            int d = $urandom_range(0, 1);
            xq.delete();
            for (int i = 0; i < 12; i++) xq.push_back(16'($urandom));
            test_job(d, 2'($urandom_range(0, 3)), 16'(n), 1'($urandom_range(0, 1)), $sformatf("random%0d", t));
        end
    endtask

    task automatic test_reset_mid();
        xq = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        mem[0][0] = 16'd4;
        for (int i = 0; i < 4; i++) mem[0][1 + i] = xq[i];
        act = 0;
        clear_caps();
        @(negedge clk);
        run[0] = 1'b1;
        mode = 2'd0;
        start_cyc = cyc + 1;
        @(negedge clk);
        run[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_b = 1'b0;
        #1;
        checks++;
        if ({busy[0], wen[0], raddr[0], waddr[0], wdata[0]} !== 41'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %h, want 0", {busy[0], wen[0], raddr[0], waddr[0], wdata[0]});
        end
        clear_caps();
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (cap_d.size() !== 0 || bcnt !== 0) begin
            fails++;
            $display("FAIL reset_mid_quiet: got %0d writes and %0d busy cycles, want 0 and 0", cap_d.size(), bcnt);
        end
        test_job(0, 2'd1, 16'd4, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_copy();
        test_prefix_wrap();
        test_delta_invert();
        test_boundaries();
        test_latency();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
